// File: rtl/probe_frame_builder.sv
// probe_frame_builder: emits delay-test Ethernet probe frames (no preamble/CRC)
// as a valid/ready byte stream. Each frame carries a 16-bit sequence number and
// the 32-bit free-running timestamp sampled when the frame was launched. Frames
// are separated by a fixed number of idle cycles.
module probe_frame_builder #(
  parameter logic [47:0] MAC_DST   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] MAC_SRC   = 48'h004E_4632_4300,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          FRAME_LEN = 60,
  parameter int          GAP_CYC   = 1000
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        enable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] seq_num,
  output logic [31:0] tx_timestamp,
  output logic [31:0] frames_sent
);

  localparam logic [13:0] LAST_IDX = 14'(FRAME_LEN - 1);
  localparam logic [13:0] GAP_INIT = 14'(GAP_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] idx_q, idx_d;
  logic [13:0] gap_q, gap_d;
  logic [31:0] ts_cnt_q;
  logic [15:0] seq_num_q, seq_num_d;
  logic [31:0] tx_ts_q, tx_ts_d;
  logic [31:0] frames_q, frames_d;
  logic [7:0]  data_q, data_d;
  logic        accept;
  logic        last_accept;

  // Frame byte at position i: a 20-byte big-endian header followed by zero pad.
  function automatic logic [7:0] byte_at(input logic [13:0] i,
                                         input logic [15:0] seq,
                                         input logic [31:0] ts);
    logic [159:0] hdr;
    int           k;
    hdr = {MAC_DST, MAC_SRC, ETHERTYPE, seq, ts};
    k   = int'(i);
    if (k < 20) return hdr[159 - 8*k -: 8];
    return 8'h00;
  endfunction

  assign accept      = (state_q == ST_SEND) && out_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge tx_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode: IDLE -> SEND on enable, SEND -> GAP on last accept,
  // GAP -> IDLE when the countdown reaches 1.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable)        state_d = ST_SEND;
      ST_SEND: if (last_accept)   state_d = ST_GAP;
      ST_GAP:  if (gap_q == 14'd1) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output decode: valid is tied to SEND so a reset drops it immediately.
  always_comb begin
    out_valid = (state_q == ST_SEND);
    out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  end

  // Datapath next-state: byte pointer, pre-fetched byte, gap and counters.
  always_comb begin
    idx_d     = idx_q;
    gap_d     = gap_q;
    seq_num_d = seq_num_q;
    tx_ts_d   = tx_ts_q;
    frames_d  = frames_q;
    data_d    = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          tx_ts_d = ts_cnt_q;
          idx_d   = 14'd0;
          data_d  = byte_at(14'd0, seq_num_q, ts_cnt_q);
        end
      end
      ST_SEND: begin
        if (last_accept) begin
          seq_num_d = seq_num_q + 16'd1;
          frames_d  = frames_q + 32'd1;
          gap_d     = GAP_INIT;
        end else if (accept) begin
          idx_d  = idx_q + 14'd1;
          data_d = byte_at(idx_q + 14'd1, seq_num_q, tx_ts_q);
        end
      end
      ST_GAP:  gap_d = gap_q - 14'd1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      gap_q     <= '0;
      seq_num_q <= '0;
      tx_ts_q   <= '0;
      frames_q  <= '0;
      data_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      seq_num_q <= seq_num_d;
      tx_ts_q   <= tx_ts_d;
      frames_q  <= frames_d;
      data_q    <= data_d;
    end
  end

  // Free-running timestamp counter, wraps naturally at 2^32.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) ts_cnt_q <= '0;
    else       ts_cnt_q <= ts_cnt_q + 32'd1;
  end

  assign out_data     = data_q;
  assign seq_num      = seq_num_q;
  assign tx_timestamp = tx_ts_q;
  assign frames_sent  = frames_q;

endmodule
